// File: rtl/ast_arb_pkg.sv
// Shared types and the circular first-set search used by the ast_arb packet multiplexer.
package ast_arb_pkg;

    typedef enum logic {IDLE, BUSY} ast_arb_state_t;

    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    // Returns the first set bit of req[n-1:0], searching upward from ptr and wrapping at n.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        logic [RR_IDX_W-1:0] pick;
        logic [RR_IDX_W-1:0] idx;
        logic                found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = RR_IDX_W'((int'(ptr) + k) % n);
            if (k < n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ast_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module ast_rr_arbiter
    import ast_arb_pkg::*;
#(
    parameter int RX_DIR = 4,
    parameter int SEL_W  = 2
) (
    input  logic [RX_DIR-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [RR_MAX-1:0]   req_ext;
    logic [RR_IDX_W-1:0] ptr_ext;
    logic [RR_IDX_W-1:0] pick;

    assign req_ext   = RR_MAX'(req);
    assign ptr_ext   = RR_IDX_W'(ptr);
    assign pick      = rr_pick(req_ext, ptr_ext, RX_DIR);
    assign gnt_idx   = SEL_W'(pick);
    assign gnt_valid = |req;

endmodule

// File: rtl/ast_arb.sv
// Avalon-ST N-to-1 packet mux with packet-granular round-robin arbitration.
//   state | meaning
//   IDLE  | no packet owned; outputs zero; pick next sop requester from rr pointer
//   BUSY  | input [grant] owns the source port until its eop beat transfers
module ast_arb
    import ast_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int RX_DIR        = 4,
    parameter int RX_SEL_WIDTH  = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                                   clk_i,
    input  logic                                   srst_i,
    input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]      ast_data_i,
    input  logic [RX_DIR-1:0]                      ast_startofpacket_i,
    input  logic [RX_DIR-1:0]                      ast_endofpacket_i,
    input  logic [RX_DIR-1:0]                      ast_valid_i,
    input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]     ast_empty_i,
    input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]   ast_channel_i,
    output logic [RX_DIR-1:0]                      ast_ready_o,
    output logic [DATA_WIDTH-1:0]                  ast_data_o,
    output logic                                   ast_startofpacket_o,
    output logic                                   ast_endofpacket_o,
    output logic                                   ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]                 ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0]               ast_channel_o,
    input  logic                                   ast_ready_i
);

    localparam logic [RX_SEL_WIDTH-1:0] LAST_IDX = RX_SEL_WIDTH'(RX_DIR - 1);

    ast_arb_state_t            state, state_nx;
    logic [RX_SEL_WIDTH-1:0]   grant, grant_nx;
    logic [RX_SEL_WIDTH-1:0]   rr_ptr, ptr_nx;
    logic [RX_DIR-1:0]         req;
    logic [RX_SEL_WIDTH-1:0]   gnt_idx;
    logic                      gnt_valid;

    // Only a sop can win; valid beats without sop wait for a packet start.
    assign req = ast_valid_i & ast_startofpacket_i;

    ast_rr_arbiter #(
        .RX_DIR (RX_DIR),
        .SEL_W  (RX_SEL_WIDTH)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= ptr_nx;
        end
    end

    always_comb begin
        state_nx            = state;
        grant_nx            = grant;
        ptr_nx              = rr_ptr;
        ast_ready_o         = '0;
        ast_valid_o         = 1'b0;
        ast_data_o          = '0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant_nx = gnt_idx;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                ast_valid_o         = ast_valid_i[grant];
                ast_data_o          = ast_data_i[grant];
                ast_startofpacket_o = ast_startofpacket_i[grant];
                ast_endofpacket_o   = ast_endofpacket_i[grant];
                ast_empty_o         = ast_empty_i[grant];
                ast_channel_o       = ast_channel_i[grant];
                ast_ready_o[grant]  = ast_ready_i;
                if (ast_valid_i[grant] && ast_ready_i && ast_endofpacket_i[grant]) begin
                    state_nx = IDLE;
                    ptr_nx   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ast_arb.sv
// Randomized and directed bench for ast_arb against a queue-based packet-level reference.
module tb_ast_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = 3;

    logic                   clk_i_tb = 1'b0;
    logic                   srst;
    logic [N-1:0][DW-1:0]   d_i;
    logic [N-1:0]           sop_i, eop_i, v_i;
    logic [N-1:0][EW-1:0]   emp_i;
    logic [N-1:0][CW-1:0]   ch_i;
    logic [N-1:0]           rdy_o;
    logic [DW-1:0]          d_o;
    logic                   sop_o, eop_o, v_o;
    logic [EW-1:0]          emp_o;
    logic [CW-1:0]          ch_o;
    logic                   rdy_i;

    always #5 clk_i_tb = ~clk_i_tb;

    ast_arb #(
        .DATA_WIDTH    (DW),
        .CHANNEL_WIDTH (CW),
        .RX_DIR        (N)
    ) dut (
        .clk_i               (clk_i_tb),
        .srst_i              (srst),
        .ast_data_i          (d_i),
        .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i   (eop_i),
        .ast_valid_i         (v_i),
        .ast_empty_i         (emp_i),
        .ast_channel_i       (ch_i),
        .ast_ready_o         (rdy_o),
        .ast_data_o          (d_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (v_o),
        .ast_empty_o         (emp_o),
        .ast_channel_o       (ch_o),
        .ast_ready_i         (rdy_i)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    beat_t src_q [N][$];
    int    vld_pct [N];
    bit    rogue [N];
    bit    rdy_pat [$];
    int    rdy_pct;
    bit    srst_next;
    int    m_owner;
    int    m_ptr;
    int    order_q [$];
    int    total;
    int    bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int src, input int len, input logic [DW-1:0] base,
                           input logic [EW-1:0] last_empty);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = base + DW'(k);
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = (k == len - 1) ? last_empty : '0;
            src_q[src].push_back(b);
        end
    endtask

    task automatic drive();
        srst = srst_next;
        for (int i = 0; i < N; i++) begin
            if (rogue[i]) begin
                v_i[i] = 1'b1; sop_i[i] = 1'b0; eop_i[i] = 1'b0;
                d_i[i] = 64'hBAD0 + DW'(i); emp_i[i] = '0;
            end else if (src_q[i].size() > 0) begin
                d_i[i]   = src_q[i][0].data;
                sop_i[i] = src_q[i][0].sop;
                eop_i[i] = src_q[i][0].eop;
                emp_i[i] = src_q[i][0].empty;
                v_i[i]   = (int'($urandom_range(99)) < vld_pct[i]);
            end else begin
                v_i[i] = 1'b0; sop_i[i] = 1'b0; eop_i[i] = 1'b0;
                d_i[i] = {$urandom, $urandom}; emp_i[i] = '0;
            end
        end
        if (rdy_pat.size() > 0) rdy_i = rdy_pat.pop_front();
        else                    rdy_i = (int'($urandom_range(99)) < rdy_pct);
    endtask

    // One clock: drive, compare against the reference at negedge, advance the reference.
    task automatic cyc();
        logic [N-1:0]  exp_rdy;
        logic          exp_v, exp_sop, exp_eop;
        logic [DW-1:0] exp_d;
        logic [EW-1:0] exp_emp;
        logic [CW-1:0] exp_ch;
        int            j;
        drive();
        @(negedge clk_i_tb);
        exp_rdy = '0; exp_v = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0;
        exp_d = '0; exp_emp = '0; exp_ch = '0;
        if (m_owner >= 0) begin
            exp_v   = v_i[m_owner];
            exp_d   = d_i[m_owner];
            exp_sop = sop_i[m_owner];
            exp_eop = eop_i[m_owner];
            exp_emp = emp_i[m_owner];
            exp_ch  = ch_i[m_owner];
            exp_rdy[m_owner] = rdy_i;
        end
        chk("valid_o", v_o, exp_v);
        chk("ready_o", rdy_o, exp_rdy);
        chk("data_o", d_o, exp_d);
        chk("sop_o", sop_o, exp_sop);
        chk("eop_o", eop_o, exp_eop);
        chk("empty_o", emp_o, exp_emp);
        chk("channel_o", ch_o, exp_ch);
        if (v_o && rdy_i && sop_o) order_q.push_back(int'(ch_o));
        for (int i = 0; i < N; i++)
            if (v_i[i] && exp_rdy[i] && !rogue[i]) void'(src_q[i].pop_front());
        if (srst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (m_owner < 0 && v_i[j] && sop_i[j]) m_owner = j;
            end
        end else if (v_i[m_owner] && rdy_i && eop_i[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
        @(posedge clk_i_tb);
        #1;
        // Upstream abandons any packet cut by reset and resends from its next sop.
        if (srst)
            for (int i = 0; i < N; i++)
                while (src_q[i].size() > 0 && !src_q[i][0].sop) void'(src_q[i].pop_front());
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pending() || m_owner >= 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
        cyc();
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_count"}, 64'(order_q.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < order_q.size(); k++)
            chk(tag, 64'(order_q[k]), 64'(exp[k]));
        order_q = {};
    endtask

    initial begin
        int e[$];
        int n;
        total = 0; bad = 0;
        m_owner = -1; m_ptr = 0;
        rdy_pct = 100;
        srst_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            ch_i[i] = CW'(8'h10 + i);
            vld_pct[i] = 100;
            rogue[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) ch_i[i] = CW'(i);
        srst = 1'b1; v_i = '0; sop_i = '0; eop_i = '0; d_i = '0; emp_i = '0; rdy_i = 1'b1;
        repeat (3) @(posedge clk_i_tb);
        #1;
        cyc();
        chk("rst_valid_o", v_o, 1'b0);
        chk("rst_ready_o", rdy_o, '0);

        // Grant order from pointer 0 with all inputs streaming 2-beat packets.
        gen_pkt(0, 2, 64'h100, 3'd0);
        gen_pkt(0, 2, 64'h110, 3'd1);
        gen_pkt(1, 2, 64'h200, 3'd2);
        gen_pkt(2, 2, 64'h300, 3'd3);
        gen_pkt(3, 2, 64'h400, 3'd4);
        drain(100);
        e = {0, 1, 2, 3, 0};
        chk_order("order_all4", e);

        // Single-beat packet on 1 while 3 waits.
        gen_pkt(1, 1, 64'h55, 3'd5);
        gen_pkt(3, 2, 64'h330, 3'd0);
        drain(50);
        e = {1, 3};
        chk_order("order_single", e);

        // Lone 3-beat packet on input 2.
        gen_pkt(2, 3, 64'hA0, 3'd3);
        drain(50);
        e = {2};
        chk_order("order_lone2", e);

        // Backpressure pattern during a 4-beat packet on input 0.
        gen_pkt(0, 4, 64'hC0, 3'd7);
        rdy_pat = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drain(50);
        e = {0};
        chk_order("order_bp", e);

        // Reset at beat 2 of a 5-beat packet; pointer must restart at 0.
        gen_pkt(2, 5, 64'h500, 3'd2);
        n = 0;
        while (!(src_q[2].size() > 0 && src_q[2][0].data == 64'h502) && n < 20) begin
            cyc();
            n++;
        end
        chk("reach_beat2", 64'(n < 20), 64'd1);
        gen_pkt(1, 2, 64'h610, 3'd0);
        gen_pkt(0, 2, 64'h600, 3'd0);
        srst_next = 1'b1;
        cyc();
        srst_next = 1'b0;
        chk("trunc_src2", 64'(src_q[2].size()), 64'd0);
        drain(50);
        e = {2, 0, 1};
        chk_order("order_rst", e);

        // Valid without sop on input 0 must never be granted.
        rogue[0] = 1'b1;
        gen_pkt(3, 2, 64'h700, 3'd1);
        drain(50);
        rogue[0] = 1'b0;
        e = {3};
        chk_order("order_nosop", e);

        // Randomized traffic, backpressure and occasional resets.
        rdy_pct = 70;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < N; i++) vld_pct[i] = int'($urandom_range(100, 50));
            for (int p = 0; p < 15; p++)
                gen_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)),
                        {$urandom, $urandom}, EW'($urandom_range(7)));
            repeat (int'($urandom_range(30, 5))) cyc();
            if (b % 3 == 1) begin
                srst_next = 1'b1;
                cyc();
                srst_next = 1'b0;
            end
            drain(2000);
            order_q = {};
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
